// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the wb_intc interrupt controller.
//   - register offsets decoded from adr_i[2:0]
//   - request FSM state type
//   - priority encoder (lowest set bit wins)
package intc_pkg;

  localparam logic [2:0] REG_RAW     = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_PENDING = 3'd2;
  localparam logic [2:0] REG_EDGE    = 3'd3;
  localparam logic [2:0] REG_ACTIVE  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when nothing is set (callers gate on |v).
  function automatic logic [3:0] prio_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intc_sync.sv
// intc_sync: two-flop synchroniser for one asynchronous interrupt line,
// plus a flop holding the previous synchronised value for edge detection.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : raw asynchronous input
//   level    : synchronised level
//   rise     : one-cycle pulse on a 0->1 transition of level
module intc_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/wb_intc.sv
// wb_intc: Wishbone-mapped interrupt controller.
// Synchronises SOURCES interrupt lines, applies per-source enable and
// edge/level mode, and presents the lowest-index pending+enabled source
// as irq_req/irq_vec to the CPU interface until irq_ack.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   cyc_i, stb_i, we_i,
//   adr_i, sel_i, dat_i : Wishbone slave inputs (adr_i[2:0] decoded)
//   ack_o, dat_o        : Wishbone acknowledge / read data
//   irq_i               : raw asynchronous interrupt lines
//   irq_req, irq_vec    : request and vector to CPU interface
//   irq_ack             : one-cycle acknowledge from CPU interface
module wb_intc
  import intc_pkg::*;
#(
  parameter int unsigned SOURCES  = 8,
  parameter logic [7:0]  VEC_BASE = 8'd64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [29:0]        adr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        dat_i,
  output logic               ack_o,
  output logic [31:0]        dat_o,
  input  logic [SOURCES-1:0] irq_i,
  output logic               irq_req,
  output logic [7:0]         irq_vec,
  input  logic               irq_ack
);

  logic [SOURCES-1:0] raw;
  logic [SOURCES-1:0] rise;
  logic [SOURCES-1:0] enable;
  logic [SOURCES-1:0] edge_mode;
  logic [SOURCES-1:0] pending;
  logic [SOURCES-1:0] pend_next;
  logic [SOURCES-1:0] clr;
  logic [SOURCES-1:0] wmask;
  logic [SOURCES-1:0] wdat;
  logic [15:0]        cand;
  logic [3:0]         win;
  logic [3:0]         act_idx;
  logic [31:0]        rdata;
  logic               wb_req;
  logic               wr;
  state_t             state;
  logic               unused;

  for (genvar g = 0; g < SOURCES; g++) begin : g_sync
    intc_sync u_sync (
      .clk   (clk_i),
      .rst   (rst_i),
      .d     (irq_i[g]),
      .level (raw[g]),
      .rise  (rise[g])
    );
  end

  assign wb_req = cyc_i & stb_i & ~ack_o;
  assign wr     = wb_req & we_i;
  assign wdat   = dat_i[SOURCES-1:0];
  assign unused = ^{adr_i, sel_i, dat_i};

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      wmask[i] = (i < 8) ? sel_i[0] : sel_i[1];
    end
  end

  // Clear sources: software write-1-to-clear and the CPU acknowledge.
  // Only edge-mode bits use clr; level bits just track the line, and a
  // fresh rise wins over a simultaneous clear.
  always_comb begin
    clr = '0;
    if (wr && adr_i[2:0] == REG_PENDING) clr = wdat & wmask;
    if (state == REQ && irq_ack) begin
      for (int unsigned i = 0; i < SOURCES; i++) begin
        if (act_idx == 4'(i)) clr[i] = 1'b1;
      end
    end
    pend_next = (edge_mode & (rise | (pending & ~clr))) | (~edge_mode & raw);
  end

  always_comb begin
    cand = '0;
    cand[SOURCES-1:0] = pending & enable;
    win = prio_index(cand);
  end

  always_comb begin
    rdata = '0;
    case (adr_i[2:0])
      REG_RAW:     rdata[SOURCES-1:0] = raw;
      REG_ENABLE:  rdata[SOURCES-1:0] = enable;
      REG_PENDING: rdata[SOURCES-1:0] = pending;
      REG_EDGE:    rdata[SOURCES-1:0] = edge_mode;
      REG_ACTIVE:  rdata[8:0]         = {irq_req, irq_vec};
      default:     rdata              = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o     <= 1'b0;
      dat_o     <= '0;
      enable    <= '0;
      edge_mode <= '0;
      pending   <= '0;
    end else begin
      ack_o   <= wb_req;
      dat_o   <= (wb_req && !we_i) ? rdata : '0;
      pending <= pend_next;
      if (wr) begin
        case (adr_i[2:0])
          REG_ENABLE: enable    <= (enable & ~wmask) | (wdat & wmask);
          REG_EDGE:   edge_mode <= (edge_mode & ~wmask) | (wdat & wmask);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
      act_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            act_idx <= win;
            irq_vec <= VEC_BASE + {4'b0000, win};
            irq_req <= 1'b1;
            state   <= REQ;
          end
        end
        // Request is held regardless of the source state until acked.
        REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            state   <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
